// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises IFU fetches and LSU loads/stores onto one memory port
module mem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter bit RR_EN = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IFU_Req_Valid,
    output logic              IFU_Req_Ready,
    input  logic [ADDR_W-1:0] IFU_Addr,
    output logic              IFU_Resp_Valid,
    output logic [DATA_W-1:0] IFU_Resp_Data,
    input  logic              IFU_Resp_Ready,
    input  logic              LSU_Req_Valid,
    output logic              LSU_Req_Ready,
    input  logic [ADDR_W-1:0] LSU_Addr,
    input  logic              LSU_Wen,
    input  logic [DATA_W-1:0] LSU_WData,
    input  logic [7:0]        LSU_WMask,
    output logic              LSU_Resp_Valid,
    output logic [DATA_W-1:0] LSU_Resp_Data,
    input  logic              LSU_Resp_Ready,
    output logic              Mem_Req_Valid,
    input  logic              Mem_Req_Ready,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Wen,
    output logic [DATA_W-1:0] Mem_WData,
    output logic [7:0]        Mem_WMask,
    input  logic              Mem_Resp_Valid,
    input  logic [DATA_W-1:0] Mem_Resp_Data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic owner_lsu;
    logic last_lsu;
    logic gnt_lsu;
    logic gnt_ifu;
    logic [DATA_W-1:0] resp_data;
    // LSU wins a tie unless round-robin says it was served last
    always_comb begin
        gnt_lsu = LSU_Req_Valid && (!IFU_Req_Valid || RR_EN == 1'b0 || !last_lsu);
        gnt_ifu = IFU_Req_Valid && !gnt_lsu;
    end
    assign IFU_Req_Ready  = state == IDLE && gnt_ifu;
    assign LSU_Req_Ready  = state == IDLE && gnt_lsu;
    assign Mem_Req_Valid  = state == ISSUE;
    assign IFU_Resp_Valid = state == RESP && !owner_lsu;
    assign LSU_Resp_Valid = state == RESP && owner_lsu;
    assign IFU_Resp_Data  = resp_data;
    assign LSU_Resp_Data  = resp_data;
    // request/issue/wait/respond sequencer; the request is latched at grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner_lsu <= 1'b0;
            last_lsu  <= 1'b0;
            Mem_Addr  <= '0;
            Mem_Wen   <= 1'b0;
            Mem_WData <= '0;
            Mem_WMask <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_lsu) begin
                        Mem_Addr  <= LSU_Addr;
                        Mem_Wen   <= LSU_Wen;
                        Mem_WData <= LSU_WData;
                        Mem_WMask <= LSU_Wen ? LSU_WMask : 8'h0;
                        owner_lsu <= 1'b1;
                        last_lsu  <= 1'b1;
                        state     <= ISSUE;
                    end else if (gnt_ifu) begin
                        Mem_Addr  <= IFU_Addr;
                        Mem_Wen   <= 1'b0;
                        Mem_WData <= '0;
                        Mem_WMask <= 8'h0;
                        owner_lsu <= 1'b0;
                        last_lsu  <= 1'b0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: if (Mem_Req_Ready) state <= WAIT;
                WAIT: begin
                    if (Mem_Resp_Valid) begin
                        resp_data <= Mem_Wen ? '0 : Mem_Resp_Data;
                        state     <= RESP;
                    end
                end
                RESP: if (owner_lsu ? LSU_Resp_Ready : IFU_Resp_Ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: fixed-priority and round-robin arbiters driven side by side against a transaction model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ifu_v, ifu_rr, lsu_v, lsu_wen, lsu_rr, mem_rdy, mem_rv;
    logic [63:0] ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
    logic [7:0] lsu_wmask;
    logic [1:0] ifu_qr, ifu_sv, lsu_qr, lsu_sv, mem_v, mem_wen;
    logic [63:0] ifu_sd [2];
    logic [63:0] lsu_sd [2];
    logic [63:0] mem_addr [2];
    logic [63:0] mem_wdata [2];
    logic [7:0] mem_wmask [2];
    int n_chk = 0;
    int n_pass = 0;
    bit last_lsu [2];

    always #5 clk = ~clk;

    // instance 0 is fixed priority, instance 1 is round-robin; both see identical stimulus
    for (genvar k = 0; k < 2; k++) begin : g_dut
        mem_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(k == 1)) u (
            .clk(clk), .rst(rst),
            .IFU_Req_Valid(ifu_v), .IFU_Req_Ready(ifu_qr[k]), .IFU_Addr(ifu_addr),
            .IFU_Resp_Valid(ifu_sv[k]), .IFU_Resp_Data(ifu_sd[k]), .IFU_Resp_Ready(ifu_rr),
            .LSU_Req_Valid(lsu_v), .LSU_Req_Ready(lsu_qr[k]), .LSU_Addr(lsu_addr),
            .LSU_Wen(lsu_wen), .LSU_WData(lsu_wdata), .LSU_WMask(lsu_wmask),
            .LSU_Resp_Valid(lsu_sv[k]), .LSU_Resp_Data(lsu_sd[k]), .LSU_Resp_Ready(lsu_rr),
            .Mem_Req_Valid(mem_v[k]), .Mem_Req_Ready(mem_rdy), .Mem_Addr(mem_addr[k]),
            .Mem_Wen(mem_wen[k]), .Mem_WData(mem_wdata[k]), .Mem_WMask(mem_wmask[k]),
            .Mem_Resp_Valid(mem_rv), .Mem_Resp_Data(mem_rdata)
        );
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] r64();
        return {$urandom, $urandom};
    endfunction

    // 0 = nobody, 1 = IFU, 2 = LSU
    function automatic int grant(input bit iv, input bit lv, input bit rr, input bit prev_lsu);
        if (iv && lv) return (rr && prev_lsu) ? 1 : 2;
        return lv ? 2 : (iv ? 1 : 0);
    endfunction

    task automatic chk_zero(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s u%0d handshakes", tag, k), {ifu_qr[k], lsu_qr[k], ifu_sv[k], lsu_sv[k], mem_v[k]}, 0);
            chk($sformatf("%s u%0d mem_addr", tag, k), mem_addr[k], 0);
            chk($sformatf("%s u%0d mem_wen", tag, k), mem_wen[k], 0);
            chk($sformatf("%s u%0d mem_wdata", tag, k), mem_wdata[k], 0);
            chk($sformatf("%s u%0d mem_wmask", tag, k), mem_wmask[k], 0);
            chk($sformatf("%s u%0d ifu_resp_data", tag, k), ifu_sd[k], 0);
            chk($sformatf("%s u%0d lsu_resp_data", tag, k), lsu_sd[k], 0);
        end
    endtask

    // called at a negedge with the arbiters idle; returns at a negedge with them idle again
    task automatic txn(input bit iv, input bit lv, input logic [63:0] ia, input logic [63:0] la,
                       input bit w, input logic [63:0] wd, input logic [7:0] wm, input logic [63:0] rd,
                       input int qd, input int rdl, input int sd);
        int g [2];
        ifu_v = iv; ifu_addr = ia; lsu_v = lv; lsu_addr = la;
        lsu_wen = w; lsu_wdata = wd; lsu_wmask = wm;
        mem_rdy = 1'b0; mem_rv = 1'b0; ifu_rr = 1'b0; lsu_rr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            g[k] = grant(iv, lv, k == 1, last_lsu[k]);
            chk($sformatf("u%0d ifu_req_ready", k), ifu_qr[k], g[k] == 1);
            chk($sformatf("u%0d lsu_req_ready", k), lsu_qr[k], g[k] == 2);
            if (g[k] != 0) last_lsu[k] = g[k] == 2;
        end
        for (int c = 0; c <= qd; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d issue mem_req_valid", k), mem_v[k], 1);
                chk($sformatf("u%0d issue mem_addr", k), mem_addr[k], g[k] == 2 ? la : ia);
                chk($sformatf("u%0d issue mem_wen", k), mem_wen[k], g[k] == 2 && w);
                chk($sformatf("u%0d issue mem_wmask", k), mem_wmask[k], (g[k] == 2 && w) ? wm : 8'h0);
                if (g[k] == 2) chk($sformatf("u%0d issue mem_wdata", k), mem_wdata[k], wd);
                chk($sformatf("u%0d issue req_ready", k), {ifu_qr[k], lsu_qr[k]}, 0);
                chk($sformatf("u%0d issue resp_valid", k), {ifu_sv[k], lsu_sv[k]}, 0);
            end
            ifu_v = 1'($urandom); lsu_v = 1'($urandom); ifu_addr = 64'h0; lsu_addr = r64();
            lsu_wen = 1'($urandom); lsu_wdata = r64(); lsu_wmask = 8'($urandom);
            mem_rdy = c == qd; mem_rv = c == 0 && qd > 0; mem_rdata = r64();
        end
        for (int c = 0; c <= rdl; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d wait mem_req_valid", k), mem_v[k], 0);
                chk($sformatf("u%0d wait req_ready", k), {ifu_qr[k], lsu_qr[k]}, 0);
                chk($sformatf("u%0d wait resp_valid", k), {ifu_sv[k], lsu_sv[k]}, 0);
            end
            ifu_v = 1'($urandom); lsu_v = 1'($urandom);
            mem_rdy = 1'b0; mem_rv = c == rdl; mem_rdata = c == rdl ? rd : r64();
            ifu_rr = 1'b1; lsu_rr = 1'b1;
        end
        for (int c = 0; c <= sd; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("u%0d resp ifu_resp_valid", k), ifu_sv[k], g[k] == 1);
                chk($sformatf("u%0d resp lsu_resp_valid", k), lsu_sv[k], g[k] == 2);
                chk($sformatf("u%0d resp data", k), g[k] == 2 ? lsu_sd[k] : ifu_sd[k], (g[k] == 2 && w) ? 64'h0 : rd);
                chk($sformatf("u%0d resp mem_req_valid", k), mem_v[k], 0);
                chk($sformatf("u%0d resp req_ready", k), {ifu_qr[k], lsu_qr[k]}, 0);
            end
            mem_rv = 1'($urandom); mem_rdata = r64();
            ifu_rr = c == sd; lsu_rr = c == sd;
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d done resp_valid", k), {ifu_sv[k], lsu_sv[k]}, 0);
            chk($sformatf("u%0d done mem_req_valid", k), mem_v[k], 0);
        end
        ifu_v = 1'b0; lsu_v = 1'b0; ifu_rr = 1'b0; lsu_rr = 1'b0; mem_rv = 1'b0;
    endtask

    task automatic idle_cycle();
        ifu_v = 1'b0; lsu_v = 1'b0; mem_rv = 1'($urandom); mem_rdata = r64();
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("u%0d idle req_ready", k), {ifu_qr[k], lsu_qr[k]}, 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk($sformatf("u%0d idle stays idle", k), {mem_v[k], ifu_sv[k], lsu_sv[k]}, 0);
        mem_rv = 1'b0;
    endtask

    task automatic reset_in_wait();
        ifu_v = 1'b1; lsu_v = 1'b0; ifu_addr = 64'h8000_0020; mem_rdy = 1'b0; mem_rv = 1'b0;
        @(negedge clk);
        ifu_v = 1'b0; mem_rdy = 1'b1;
        @(negedge clk);
        mem_rdy = 1'b0;
        for (int k = 0; k < 2; k++) chk($sformatf("u%0d pre-reset in wait", k), {mem_v[k], ifu_sv[k]}, 0);
        #2 rst = 1'b1;
        #1 chk_zero("rst_wait");
        @(negedge clk);
        rst = 1'b0;
        last_lsu[0] = 1'b0;
        last_lsu[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rv = 1'b1; mem_rdata = r64(); ifu_rr = 1'b1; lsu_rr = 1'b1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) chk($sformatf("u%0d post-reset no resp", k), {ifu_sv[k], lsu_sv[k], mem_v[k]}, 0);
        end
        mem_rv = 1'b0; ifu_rr = 1'b0; lsu_rr = 1'b0;
    endtask

    initial begin
        ifu_v = 1'b0; ifu_rr = 1'b0; lsu_v = 1'b0; lsu_wen = 1'b0; lsu_rr = 1'b0;
        mem_rdy = 1'b0; mem_rv = 1'b0; ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0;
        lsu_wmask = '0; mem_rdata = '0;
        last_lsu[0] = 1'b0;
        last_lsu[1] = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            txn(1, 1, 64'h8000_0010 + 64'(i * 4), 64'h8000_2000 + 64'(i * 8), 0, r64(), 8'hFF, r64(), 0, 0, 0);
        txn(1, 0, 64'h8000_0000, r64(), 0, r64(), 8'hFF, 64'h0000_0013_0010_0093, 0, 0, 0);
        txn(0, 1, r64(), 64'h8000_1000, 1, 64'hDEAD_BEEF, 8'h0F, r64(), 0, 0, 0);
        txn(0, 1, r64(), 64'h8000_3000, 0, r64(), 8'hFF, r64(), 5, 4, 3);
        txn(1, 0, 64'h8000_0004, r64(), 0, r64(), 8'h0, r64(), 0, 0, 0);
        reset_in_wait();
        txn(1, 0, 64'h8000_0008, r64(), 0, r64(), 8'h0, r64(), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            int s;
            if ($urandom_range(3) == 0) idle_cycle();
            s = $urandom_range(2);
            txn(s != 1, s != 0, r64(), r64(), 1'($urandom), r64(), 8'($urandom), r64(),
                $urandom_range(3), $urandom_range(3), $urandom_range(3));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
